spi_controller: RTL

SPI initiator that serialises register-write requests into 16-bit SPI mode-0 frames for the on-chip `spi_peripheral` register file. Each frame is {1'b1 write flag, 7-bit address, 8-bit data}, MSB first. The block sits on the test/host side of the design and drives `SCLK`, `COPI` and `nCS` slowly enough for the peripheral's 2-flop synchronisers. A valid/ready request port feeds it, and it reports completion with a one-cycle `done` pulse.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_phase_timer.sv | 29 ++
 rtl/spi_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
// Frame layout is {write flag, 7-bit address, 8-bit data}, MSB first.
// Contents: frame widths, register map, FSM state enum, max helper.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  localparam logic WRITE_FLAG = 1'b1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter whose terminal-count strobe times every FSM phase.
// Latency: tc asserts load_val+1 cycles after a load (count reaches zero).
// Backpressure: none; load always wins, counter parks at zero otherwise.
// Ports: clk, rst_n (sync, active-low), load/load_val in, tc out.
module spi_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one register write per request into a 16-bit frame.
// Latency: nCS falls 1 cycle after accept, done at 1+CS_SETUP+32*HALF_PERIOD.
// Backpressure: req_ready only in IDLE; requests during a frame or the gap are ignored.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_addr/req_data in;
//        busy, done (1-cycle pulse), SCLK, COPI, nCS out (all registered).
module spi_controller import spi_pkg::*; #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_GAP      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              COPI,
  output logic              nCS
);

  localparam int PW = $clog2(max3(HALF_PERIOD, CS_SETUP, CS_GAP)) + 1;
  // Each phase lasts N cycles: load N-1, transition on the zero cycle.
  localparam logic [PW-1:0] HALF_LD  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] GAP_LD   = PW'(CS_GAP - 1);

  spi_state_t           state_q, state_d;
  logic                 phase_q, phase_d;   // 1: SCLK-high half of a bit
  logic [4:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic                 done_d;
  logic                 tmr_load;
  logic [PW-1:0]        tmr_val;
  logic                 tmr_tc;

  spi_phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = SETUP;
          sh_d     = {WRITE_FLAG, req_addr, req_data};
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          state_d  = SHIFT;
          phase_d  = 1'b1;
          bit_d    = 5'd0;
          tmr_load = 1'b1;
          tmr_val  = HALF_LD;
        end
      end
      SHIFT: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_LD;
          if (phase_q) begin
            // Falling edge: present the next bit while SCLK is low.
            phase_d = 1'b0;
            sh_d    = {sh_q[FRAME_W-2:0], 1'b0};
            // The low half of the last bit is timed by HOLD.
            if (bit_q == 5'd15) state_d = HOLD;
          end else begin
            phase_d = 1'b1;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (tmr_tc) begin
          state_d  = GAP;
          done_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      GAP: begin
        if (tmr_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      bit_q     <= 5'd0;
      sh_q      <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SCLK      <= 1'b0;
      COPI      <= 1'b0;
      nCS       <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      req_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      SCLK      <= (state_d == SHIFT) && phase_d;
      COPI      <= ((state_d == SETUP) || (state_d == SHIFT)) && sh_d[FRAME_W-1];
      nCS       <= !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    end
  end

endmodule
